// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing a shared-memory, shared-ALU
// MIPS datapath. Memory accesses stall on mem_ready.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unrecognised opcode -> S_TRAP).
module mips_multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OP,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             BranchEQ,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic [1:0]       PCSource,
  output logic [2:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             Link,
  output logic [CNT_W-1:0] instr_count,
  output logic             trap
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, opcode capture on DECODE exit, retire counting
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = OP;
        case (OP)
          6'h00:                      state_d = S_EXEC_R;
          6'h08, 6'h0d, 6'h0c, 6'h0f: state_d = S_EXEC_I;
          6'h23, 6'h2b:               state_d = S_MEM_ADDR;
          6'h04, 6'h05:               state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          6'h03:                      state_d = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                    state_d = S_TRAP;
`else
          default:                    state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RST;
    endcase
    // An instruction retires on entry to FETCH from any state other than
    // reset; a stalled FETCH holding itself is not an entry.
    cnt_d = cnt_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Moore output decode; mem_ready only gates IR/PC load in FETCH
  always_comb begin
    PCWrite  = 1'b0;
    BranchEQ = 1'b0;
    BranchNE = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    PCSource = 2'b00;
    ALUOp    = 3'b000;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    Link     = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          6'h0d:   ALUOp = 3'b010;
          6'h0c:   ALUOp = 3'b011;
          6'h0f:   ALUOp = 3'b101;
          default: ALUOp = 3'b000;
        endcase
      end
      S_WB_I:     RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        BranchEQ = (op_q == 6'h04);
        BranchNE = (op_q == 6'h05);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        ALUOp    = 3'b110;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        Link     = 1'b1;
        ALUOp    = 3'b100;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     trap = 1'b1;
`endif
      default: ;
    endcase
  end

  assign instr_count = cnt_q;

endmodule
